// File: rtl/uart_transmitter.sv
// UART transmitter: sends start bit, LSB-first data, optional parity and stop bits,
// with each bit paced by OVERSAMPLE pulses of the shared oversampling tick.
module uart_transmitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  tx_ready,
  output logic                  tx_done
);

  localparam int unsigned S_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned B_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state, state_d;
  logic [S_W-1:0]        s_cnt, s_cnt_d;
  logic [B_W-1:0]        b_cnt, b_cnt_d;
  logic                  stop_cnt, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  parity_bit, parity_bit_d;
  logic                  tx_d, tx_ready_d, tx_done_d;
  logic                  bit_end;

  assign bit_end = (state != S_IDLE) && tick && (s_cnt == S_W'(OVERSAMPLE - 1));

  // Next-state and registered-output logic; tx follows the current state one clk later.
  always_comb begin
    state_d      = state;
    s_cnt_d      = s_cnt;
    b_cnt_d      = b_cnt;
    stop_cnt_d   = stop_cnt;
    shreg_d      = shreg;
    parity_bit_d = parity_bit;
    tx_d         = 1'b1;
    tx_done_d    = 1'b0;

    if ((state != S_IDLE) && tick) begin
      s_cnt_d = bit_end ? '0 : s_cnt + S_W'(1);
    end

    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shreg_d      = data_in;
          parity_bit_d = (^data_in) ^ 1'(PARITY_ODD);
          s_cnt_d      = '0;
          b_cnt_d      = '0;
          stop_cnt_d   = 1'b0;
          state_d      = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shreg[0];
        if (bit_end) begin
          shreg_d = shreg >> 1;
          b_cnt_d = b_cnt + B_W'(1);
          if (b_cnt == B_W'(DATA_WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        tx_d = parity_bit;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_d   = S_IDLE;
            tx_done_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready stays up through the first START cycle and rises with the done pulse.
    tx_ready_d = (state == S_IDLE) || (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      s_cnt      <= '0;
      b_cnt      <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_d;
      s_cnt      <= s_cnt_d;
      b_cnt      <= b_cnt_d;
      stop_cnt   <= stop_cnt_d;
      shreg      <= shreg_d;
      parity_bit <= parity_bit_d;
      tx         <= tx_d;
      tx_ready   <= tx_ready_d;
      tx_done    <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: 8N1, 8E1, 8O1 and 8N2 instances share stimulus
// and are checked against hand-computed bit patterns and done/ready timing.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] tx_v, rdy_v, done_v;

  int errors = 0;
  int checks = 0;
  int ph = 0;

  always #5 clk = ~clk;

  // One-clk tick every 4 clk, driven between active edges.
  always @(negedge clk) begin
    ph = (ph + 1) % 4;
    tick = (ph == 0);
  end

  uart_transmitter u_8n1 (.clk(clk), .rst(rst), .tick(tick), .tx_start(tx_start), .data_in(data_in),
                          .tx(tx_v[0]), .tx_ready(rdy_v[0]), .tx_done(done_v[0]));
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (.clk(clk), .rst(rst), .tick(tick),
                          .tx_start(tx_start), .data_in(data_in),
                          .tx(tx_v[1]), .tx_ready(rdy_v[1]), .tx_done(done_v[1]));
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (.clk(clk), .rst(rst), .tick(tick),
                          .tx_start(tx_start), .data_in(data_in),
                          .tx(tx_v[2]), .tx_ready(rdy_v[2]), .tx_done(done_v[2]));
  uart_transmitter #(.STOP_BITS(2)) u_8n2 (.clk(clk), .rst(rst), .tick(tick),
                          .tx_start(tx_start), .data_in(data_in),
                          .tx(tx_v[3]), .tx_ready(rdy_v[3]), .tx_done(done_v[3]));

  task automatic chk(input string tag, input int id, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed=%b expected=%b", tag, id, got, exp);
    end
  endtask

  // base = cycle (after acceptance) at which the start bit's state ends.
  task automatic check_cycle(input int c, input int id, input logic [10:0] eb, input int nb,
                             input int base);
    int last;
    last = base + 64 * (nb - 1);
    if (c == base - 32) chk("start_bit", id, tx_v[id], eb[0]);
    for (int k = 1; k < nb; k++) begin
      if (c == base + 64 * (k - 1) + 32) chk($sformatf("bit%0d", k), id, tx_v[id], eb[k]);
    end
    if (c == last - 1) begin
      chk("done_early", id, done_v[id], 1'b0);
      chk("rdy_busy", id, rdy_v[id], 1'b0);
    end
    if (c == last) begin
      chk("done_pulse", id, done_v[id], 1'b1);
      chk("rdy_at_done", id, rdy_v[id], 1'b1);
    end
    if (c == last + 1) chk("done_width", id, done_v[id], 1'b0);
  endtask

  // Assert tx_start in a tick cycle so the start bit spans exactly 64 clk.
  task automatic start_frame(input logic [7:0] d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!tick && n < 8);
    tx_start = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [10:0] e0, input logic [10:0] e1,
                           input logic [10:0] e2, input logic [10:0] e3, input bit busy,
                           input bit b2b, input logic [10:0] eb);
    logic [10:0] ev [4];
    int nb [4];
    int cmax;
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    nb[0] = 10; nb[1] = 11; nb[2] = 11; nb[3] = 11;
    cmax = b2b ? 1282 : 706;
    start_frame(d);
    for (int id = 0; id < 4; id++) begin
      chk("tx_lag", id, tx_v[id], 1'b1);
      chk("rdy_lag", id, rdy_v[id], 1'b1);
    end
    if (busy) begin
      tx_start = 1'b1;
      data_in  = 8'h55;
    end
    for (int c = 1; c <= cmax; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        for (int id = 0; id < 4; id++) begin
          chk("tx_fall", id, tx_v[id], 1'b0);
          chk("rdy_drop", id, rdy_v[id], 1'b0);
        end
      end
      for (int id = 0; id < 4; id++) check_cycle(c, id, ev[id], nb[id], 64);
      if (busy && c == 600) tx_start = 1'b0;
      if (b2b) begin
        if (c == 640) begin
          tx_start = 1'b1;
          data_in  = 8'h34;
        end
        if (c == 641) begin
          tx_start = 1'b0;
          chk("b2b_idle_clk", 0, tx_v[0], 1'b1);
        end
        if (c == 642) chk("b2b_start", 0, tx_v[0], 1'b0);
        check_cycle(c, 0, eb, 10, 704);
      end
    end
  endtask

  initial begin
    bit seen_done;
    bit seen_low;

    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 4; id++) begin
      chk("rst_tx", id, tx_v[id], 1'b1);
      chk("rst_rdy", id, rdy_v[id], 1'b1);
      chk("rst_done", id, done_v[id], 1'b0);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 0xA5: four ones -> even parity 0, odd parity 1
    run_frame(8'hA5, 11'b0_1_10100101_0, 11'b1_0_10100101_0, 11'b1_1_10100101_0,
              11'b1_1_10100101_0, 1'b0, 1'b0, 11'b0);
    // 0x07: three ones -> even parity 1, odd parity 0
    run_frame(8'h07, 11'b0_1_00000111_0, 11'b1_1_00000111_0, 11'b1_0_00000111_0,
              11'b1_1_00000111_0, 1'b0, 1'b0, 11'b0);
    run_frame(8'h00, 11'b0_1_00000000_0, 11'b1_0_00000000_0, 11'b1_1_00000000_0,
              11'b1_1_00000000_0, 1'b0, 1'b0, 11'b0);
    // 0x12 with 0x55 requested while busy, then 0x34 back-to-back on the 8N1 instance
    run_frame(8'h12, 11'b0_1_00010010_0, 11'b1_0_00010010_0, 11'b1_1_00010010_0,
              11'b1_1_00010010_0, 1'b1, 1'b1, 11'b0_1_00110100_0);

    // Reset mid-frame for 3 clk
    start_frame(8'h00);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int id = 0; id < 4; id++) begin
      chk("midrst_tx", id, tx_v[id], 1'b1);
      chk("midrst_rdy", id, rdy_v[id], 1'b1);
      chk("midrst_done", id, done_v[id], 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    seen_low  = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      if (|done_v) seen_done = 1'b1;
      if (tx_v != 4'hF) seen_low = 1'b1;
    end
    chk("no_done_after_rst", 0, seen_done, 1'b0);
    chk("idle_after_rst", 0, seen_low, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
